// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI3 encodings, channel widths and FSM states for axi_sram_slave.
package axi_sram_slave_pkg;
  localparam int LID_W    = 4;
  localparam int LADDR_W  = 32;
  localparam int LLEN_W   = 4;
  localparam int LSIZE_W  = 3;
  localparam int LBURST_W = 2;
  localparam int LRESP_W  = 2;
  localparam int LDATA_W  = 32;
  localparam int LSTRB_W  = 4;

  localparam logic [LBURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [LBURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [LBURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [LRESP_W-1:0]  RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_WRESP = 2'd3
  } state_t;

  // Only power-of-two beat counts form a legal wrap window.
  function automatic logic wrap_len_ok(input logic [LLEN_W-1:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction
endpackage

// File: rtl/axi_sram_rd_buf.sv
// Two-entry {data, last} FIFO that absorbs SRAM read returns while rready is low.
module axi_sram_rd_buf
  import axi_sram_slave_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [LDATA_W-1:0] wdata,
  input  logic               wlast,
  output logic [LDATA_W-1:0] rdata,
  output logic               rlast,
  output logic [1:0]         count,
  output logic               full,
  output logic               empty
);
  logic [LDATA_W:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wdata, wlast};
  end

  assign {rdata, rlast} = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a 1-cycle synchronous SRAM.
// Optional WRAP burst support: define AXI_SRAM_SLAVE_WRAP_EN.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LID_W-1:0]    arid,
  input  logic [LADDR_W-1:0]  araddr,
  input  logic [LLEN_W-1:0]   arlen,
  input  logic [LSIZE_W-1:0]  arsize,
  input  logic [LBURST_W-1:0] arburst,
  input  logic [1:0]          arlock,
  input  logic [3:0]          arcache,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [LID_W-1:0]    rid,
  output logic [LDATA_W-1:0]  rdata,
  output logic [LRESP_W-1:0]  rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [LID_W-1:0]    awid,
  input  logic [LADDR_W-1:0]  awaddr,
  input  logic [LLEN_W-1:0]   awlen,
  input  logic [LSIZE_W-1:0]  awsize,
  input  logic [LBURST_W-1:0] awburst,
  input  logic [1:0]          awlock,
  input  logic [3:0]          awcache,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [LID_W-1:0]    wid,
  input  logic [LDATA_W-1:0]  wdata,
  input  logic [LSTRB_W-1:0]  wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [LID_W-1:0]    bid,
  output logic [LRESP_W-1:0]  bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                ram_en,
  output logic [LSTRB_W-1:0]  ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [LDATA_W-1:0]  ram_wdata,
  input  logic [LDATA_W-1:0]  ram_rdata
);
  state_t               state;
  logic                 last_grant_rd;
  logic [LID_W-1:0]     id_q;
  logic [LLEN_W-1:0]    beats_left;
  logic                 rd_done;
  logic [LADDR_W-1:0]   addr_q;
  logic [LADDR_W-1:0]   addr_nxt;
  logic [LSIZE_W-1:0]   size_q;
  logic [LBURST_W-1:0]  burst_q;
  logic                 vld_p1;
  logic                 last_p1;
  logic                 choose_wr, ar_hs, aw_hs, w_hs, r_pop, rd_issue;
  logic                 buf_push, buf_pop, buf_full, buf_empty, buf_last;
  logic [1:0]           buf_count;
  logic [LDATA_W-1:0]   buf_data;
  logic                 unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, buf_full};

  // Ties go to whichever channel was not granted last.
  assign choose_wr = awvalid && (!arvalid || last_grant_rd);
  assign arready   = (state == ST_IDLE) && !reset && !choose_wr;
  assign awready   = (state == ST_IDLE) && !reset && choose_wr;
  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign wready    = (state == ST_WR);
  assign w_hs      = wvalid && wready;

  // A word leaving the SRAM this cycle bypasses the buffer when it is empty.
  assign rvalid   = !buf_empty || vld_p1;
  assign rdata    = buf_empty ? ram_rdata : buf_data;
  assign rlast    = buf_empty ? (vld_p1 && last_p1) : buf_last;
  assign r_pop    = rvalid && rready;
  assign buf_push = vld_p1 && !(buf_empty && rready);
  assign buf_pop  = rready && !buf_empty;
  assign rd_issue = (state == ST_RD) && !rd_done &&
                    (({1'b0, buf_count} + {2'b0, vld_p1}) < (3'd2 + {2'b0, r_pop}));

  assign ram_en    = rd_issue || w_hs;
  assign ram_we    = w_hs ? wstrb : '0;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = wdata;
  assign rid       = id_q;
  assign bid       = id_q;
  assign rresp     = RESP_OKAY;
  assign bresp     = RESP_OKAY;
  assign bvalid    = (state == ST_WRESP);

`ifdef AXI_SRAM_SLAVE_WRAP_EN
  logic [LLEN_W-1:0]  len_q;
  logic [LADDR_W-1:0] wrap_mask;
  assign wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
`endif

  always_comb begin
    addr_nxt = addr_q + (32'd1 << size_q);
    if (burst_q == BURST_FIXED) addr_nxt = addr_q;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    else if (burst_q == BURST_WRAP && wrap_len_ok(len_q))
      addr_nxt = (addr_q & ~wrap_mask) | (addr_nxt & wrap_mask);
`endif
  end

  axi_sram_rd_buf u_rd_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (ram_rdata),
    .wlast (last_p1),
    .rdata (buf_data),
    .rlast (buf_last),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant_rd <= 1'b0;
      id_q          <= '0;
      beats_left    <= '0;
      rd_done       <= 1'b0;
      vld_p1        <= 1'b0;
    end else begin
      vld_p1 <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            state         <= ST_RD;
            last_grant_rd <= 1'b1;
            id_q          <= arid;
            beats_left    <= arlen;
            rd_done       <= 1'b0;
          end else if (aw_hs) begin
            state         <= ST_WR;
            last_grant_rd <= 1'b0;
            id_q          <= awid;
            beats_left    <= awlen;
          end
        end
        ST_RD: begin
          if (rd_issue) begin
            if (beats_left == '0) rd_done <= 1'b1;
            else                  beats_left <= beats_left - 1'b1;
          end
          if (r_pop && rlast) state <= ST_IDLE;
        end
        ST_WR: begin
          if (w_hs) begin
            if (wlast || beats_left == '0) state <= ST_WRESP;
            else                           beats_left <= beats_left - 1'b1;
          end
        end
        ST_WRESP: begin
          if (bready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: SRAM access issued, last-beat tag follows the word ----
  always_ff @(posedge clk) begin
    last_p1 <= (beats_left == '0);
    if (ar_hs) begin
      addr_q  <= araddr;
      size_q  <= arsize;
      burst_q <= arburst;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
      len_q   <= arlen;
`endif
    end else if (aw_hs) begin
      addr_q  <= awaddr;
      size_q  <= awsize;
      burst_q <= awburst;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
      len_q   <= awlen;
`endif
    end else if (rd_issue || w_hs) begin
      addr_q <= addr_nxt;
    end
  end
endmodule
